// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage and IF/ID pipeline register.
// Owns the PC, keeps at most one instruction-memory request outstanding,
// buffers a response that arrives while ID is stalled, and applies
// redirects from ID and the Stall / IF_ID_flush controls from the hazard unit.
// Optional feature macro: FETCH_PERF_CNT_EN adds perf_fetch_cnt / perf_drop_cnt.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Stall,
    input  logic        IF_ID_flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        IF_ID_valid,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] IF_ID_pc4,
    output logic [31:0] IF_ID_inst,
    output logic        fetch_busy
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_drop_cnt
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic [31:0] r_hold_pc;
    logic [31:0] r_hold_inst;
    logic        r_drop;

    logic        r_if_vld;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_pc4;
    logic [31:0] r_if_inst;

    logic [31:0] w_redir_pc;
    logic        w_hs;
    logic        w_wait_take;
    logic        w_hold_take;
    logic        w_consume;
    logic        w_load;
    logic [31:0] w_src_pc;
    logic [31:0] w_src_pc4;
    logic [31:0] w_src_inst;

    // Redirect targets are forced to word alignment.
    assign w_redir_pc  = redirect_pc & 32'hFFFF_FFFC;

    // No request is presented while reset is asserted.
    assign w_hs        = (r_state == S_REQ) && !rst && imem_req_ready;

    // An instruction leaves the fetch stage either straight from memory or from
    // the hold buffer; a redirect in the same cycle makes it stale instead.
    assign w_wait_take = (r_state == S_WAIT) && imem_rsp_valid && !r_drop
                         && !redirect_valid && !Stall;
    assign w_hold_take = (r_state == S_HOLD) && !redirect_valid && !Stall;
    assign w_consume   = w_wait_take || w_hold_take;
    // A flush in the same cycle still advances the PC but kills the slot.
    assign w_load      = w_consume && !IF_ID_flush;

    assign w_src_pc    = (r_state == S_HOLD) ? r_hold_pc : r_req_pc;
    assign w_src_inst  = (r_state == S_HOLD) ? r_hold_inst : imem_rsp_data;
    assign w_src_pc4   = w_src_pc + 32'd4;

    assign imem_req_valid = (r_state == S_REQ) && !rst;
    assign imem_addr      = r_pc;
    assign fetch_busy     = (r_state == S_WAIT) || (r_state == S_HOLD);

    assign IF_ID_valid = r_if_vld;
    assign IF_ID_pc    = r_if_pc;
    assign IF_ID_pc4   = r_if_pc4;
    assign IF_ID_inst  = r_if_inst;

    // Fetch FSM: PC, outstanding-request tracking, drop flag and hold buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
            r_drop  <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_hs) begin
                        r_req_pc <= r_pc;
                        r_state  <= S_WAIT;
                        // Request already issued to the old path: discard its reply.
                        r_drop   <= redirect_valid;
                    end
                    if (redirect_valid) begin
                        r_pc <= w_redir_pc;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (r_drop) begin
                            r_drop  <= 1'b0;
                            r_state <= S_REQ;
                        end else if (redirect_valid) begin
                            r_state <= S_REQ;
                        end else if (!Stall) begin
                            r_pc    <= w_src_pc4;
                            r_state <= S_REQ;
                        end else begin
                            r_hold_pc   <= r_req_pc;
                            r_hold_inst <= imem_rsp_data;
                            r_state     <= S_HOLD;
                        end
                    end else if (redirect_valid) begin
                        r_drop <= 1'b1;
                    end
                    if (redirect_valid) begin
                        r_pc <= w_redir_pc;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        r_pc    <= w_redir_pc;
                        r_state <= S_REQ;
                    end else if (!Stall) begin
                        r_pc    <= w_src_pc4;
                        r_state <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_REQ;
                end
            endcase
        end
    end

    // IF/ID register: flush beats stall; an idle unstalled cycle inserts a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_vld  <= 1'b0;
            r_if_pc   <= RESET_PC;
            r_if_pc4  <= RESET_PC + 32'd4;
            r_if_inst <= NOP_INST;
        end else if (IF_ID_flush) begin
            r_if_vld  <= 1'b0;
            r_if_inst <= NOP_INST;
        end else if (w_load) begin
            r_if_vld  <= 1'b1;
            r_if_pc   <= w_src_pc;
            r_if_pc4  <= w_src_pc4;
            r_if_inst <= w_src_inst;
        end else if (!Stall) begin
            r_if_vld  <= 1'b0;
            r_if_inst <= NOP_INST;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_drop;
    logic        w_discard;

    // Responses thrown away: stale reply, abandoned hold buffer, or flushed delivery.
    assign w_discard = ((r_state == S_WAIT) && imem_rsp_valid && (r_drop || redirect_valid))
                       || ((r_state == S_HOLD) && redirect_valid)
                       || (w_consume && IF_ID_flush);

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_drop_cnt  = r_perf_drop;

    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetch <= 32'd0;
            r_perf_drop  <= 32'd0;
        end else begin
            if (w_load) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (w_discard) begin
                r_perf_drop <= r_perf_drop + 32'd1;
            end
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: per-cycle directed vector table
// followed by a streaming sequence with a simple one-cycle memory model.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        Stall;
    logic        IF_ID_flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        IF_ID_valid;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_pc4;
    logic [31:0] IF_ID_inst;
    logic        fetch_busy;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_drop_cnt;
`endif

    if_fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .Stall          (Stall),
        .IF_ID_flush    (IF_ID_flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .IF_ID_valid    (IF_ID_valid),
        .IF_ID_pc       (IF_ID_pc),
        .IF_ID_pc4      (IF_ID_pc4),
        .IF_ID_inst     (IF_ID_inst),
        .fetch_busy     (fetch_busy)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_drop_cnt  (perf_drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        rspv;
        logic [31:0] rdata;
        logic        e_rqv;
        logic [31:0] e_addr;
        logic        e_busy;
        logic        e_vld;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    localparam int NV = 28;
    vec_t tbl [NV];

    int n_chk  = 0;
    int n_pass = 0;

    function automatic vec_t mk(
        input logic rst_i, input logic stall_i, input logic flush_i,
        input logic rv_i, input logic [31:0] rpc_i, input logic rdy_i,
        input logic rspv_i, input logic [31:0] rdata_i,
        input logic e_rqv_i, input logic [31:0] e_addr_i, input logic e_busy_i,
        input logic e_vld_i, input logic [31:0] e_pc_i, input logic [31:0] e_inst_i);
        vec_t v;
        v.rst = rst_i;     v.stall = stall_i; v.flush = flush_i;
        v.rv = rv_i;       v.rpc = rpc_i;     v.rdy = rdy_i;
        v.rspv = rspv_i;   v.rdata = rdata_i;
        v.e_rqv = e_rqv_i; v.e_addr = e_addr_i; v.e_busy = e_busy_i;
        v.e_vld = e_vld_i; v.e_pc = e_pc_i;   v.e_inst = e_inst_i;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s got %h expected %h", nm, act, exp);
    endtask

    task automatic drive_idle();
        rst = 1'b0; Stall = 1'b0; IF_ID_flush = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'd0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'd0;
    endtask

    initial begin
        logic [31:0] exp_pc4;
        logic [31:0] exp_pc;
        logic [31:0] pend_addr;
        logic [31:0] hs_addr;
        logic        pending;
        logic        hs;
        logic        st;
        logic        rsp_sent;
        int          got;

        //          rst st fl rv rpc           rdy rspv rdata           rqv addr          busy vld pc            inst
        tbl[0]  = mk(1, 0, 0, 0, 32'h0,        0,  0,   32'h0,          0,  32'h0,        0,   0,  32'h0,        NOP);
        tbl[1]  = mk(0, 0, 0, 0, 32'h0,        1,  0,   32'h0,          0,  32'h0,        1,   0,  32'h0,        NOP);
        tbl[2]  = mk(0, 0, 0, 0, 32'h0,        1,  1,   32'h00A00093,   1,  32'h4,        0,   1,  32'h0,        32'h00A00093);
        tbl[3]  = mk(0, 1, 0, 0, 32'h0,        1,  0,   32'h0,          0,  32'h4,        1,   1,  32'h0,        32'h00A00093);
        tbl[4]  = mk(0, 1, 0, 0, 32'h0,        0,  1,   32'h11111111,   0,  32'h4,        1,   1,  32'h0,        32'h00A00093);
        tbl[5]  = mk(0, 1, 0, 0, 32'h0,        0,  0,   32'h0,          0,  32'h4,        1,   1,  32'h0,        32'h00A00093);
        tbl[6]  = mk(0, 0, 0, 0, 32'h0,        0,  0,   32'h0,          1,  32'h8,        0,   1,  32'h4,        32'h11111111);
        tbl[7]  = mk(0, 0, 0, 0, 32'h0,        1,  0,   32'h0,          0,  32'h8,        1,   0,  32'h4,        NOP);
        tbl[8]  = mk(0, 0, 0, 1, 32'h103,      0,  0,   32'h0,          0,  32'h100,      1,   0,  32'h4,        NOP);
        tbl[9]  = mk(0, 0, 0, 0, 32'h0,        0,  1,   32'hDEADBEEF,   1,  32'h100,      0,   0,  32'h4,        NOP);
        tbl[10] = mk(0, 0, 0, 0, 32'h0,        1,  0,   32'h0,          0,  32'h100,      1,   0,  32'h4,        NOP);
        tbl[11] = mk(0, 0, 0, 0, 32'h0,        0,  1,   32'h22222222,   1,  32'h104,      0,   1,  32'h100,      32'h22222222);
        tbl[12] = mk(0, 1, 1, 0, 32'h0,        0,  0,   32'h0,          1,  32'h104,      0,   0,  32'h100,      NOP);
        tbl[13] = mk(0, 0, 0, 1, 32'hFFFFFFFC, 0,  0,   32'h0,          1,  32'hFFFFFFFC, 0,   0,  32'h100,      NOP);
        tbl[14] = mk(0, 0, 0, 0, 32'h0,        1,  0,   32'h0,          0,  32'hFFFFFFFC, 1,   0,  32'h100,      NOP);
        tbl[15] = mk(0, 0, 0, 0, 32'h0,        0,  1,   32'h33333333,   1,  32'h0,        0,   1,  32'hFFFFFFFC, 32'h33333333);
        tbl[16] = mk(0, 0, 0, 0, 32'h0,        1,  0,   32'h0,          0,  32'h0,        1,   0,  32'hFFFFFFFC, NOP);
        tbl[17] = mk(1, 0, 0, 0, 32'h0,        0,  0,   32'h0,          0,  32'h0,        0,   0,  32'h0,        NOP);
        tbl[18] = mk(0, 0, 0, 0, 32'h0,        0,  1,   32'h44444444,   1,  32'h0,        0,   0,  32'h0,        NOP);
        tbl[19] = mk(0, 0, 0, 0, 32'h0,        1,  0,   32'h0,          0,  32'h0,        1,   0,  32'h0,        NOP);
        tbl[20] = mk(0, 0, 0, 0, 32'h0,        0,  1,   32'h55555555,   1,  32'h4,        0,   1,  32'h0,        32'h55555555);
        tbl[21] = mk(0, 0, 0, 0, 32'h0,        1,  0,   32'h0,          0,  32'h4,        1,   0,  32'h0,        NOP);
        tbl[22] = mk(0, 1, 0, 0, 32'h0,        0,  1,   32'h66666666,   0,  32'h4,        1,   0,  32'h0,        NOP);
        tbl[23] = mk(0, 1, 0, 1, 32'h200,      0,  0,   32'h0,          1,  32'h200,      0,   0,  32'h0,        NOP);
        tbl[24] = mk(0, 0, 0, 1, 32'h300,      1,  0,   32'h0,          0,  32'h300,      1,   0,  32'h0,        NOP);
        tbl[25] = mk(0, 0, 0, 0, 32'h0,        0,  1,   32'h77777777,   1,  32'h300,      0,   0,  32'h0,        NOP);
        tbl[26] = mk(0, 0, 0, 0, 32'h0,        1,  0,   32'h0,          0,  32'h300,      1,   0,  32'h0,        NOP);
        tbl[27] = mk(0, 0, 1, 0, 32'h0,        0,  1,   32'h88888888,   1,  32'h304,      0,   0,  32'h0,        NOP);

        drive_idle();

        for (int i = 0; i < NV; i++) begin
            rst            = tbl[i].rst;
            Stall          = tbl[i].stall;
            IF_ID_flush    = tbl[i].flush;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            imem_req_ready = tbl[i].rdy;
            imem_rsp_valid = tbl[i].rspv;
            imem_rsp_data  = tbl[i].rdata;
            @(posedge clk);
            #1;
            exp_pc4 = tbl[i].e_pc + 32'd4;
            chk($sformatf("v%0d_req_valid", i), {31'd0, imem_req_valid}, {31'd0, tbl[i].e_rqv});
            chk($sformatf("v%0d_addr", i),      imem_addr,               tbl[i].e_addr);
            chk($sformatf("v%0d_busy", i),      {31'd0, fetch_busy},     {31'd0, tbl[i].e_busy});
            chk($sformatf("v%0d_valid", i),     {31'd0, IF_ID_valid},    {31'd0, tbl[i].e_vld});
            chk($sformatf("v%0d_pc", i),        IF_ID_pc,                tbl[i].e_pc);
            chk($sformatf("v%0d_pc4", i),       IF_ID_pc4,               exp_pc4);
            chk($sformatf("v%0d_inst", i),      IF_ID_inst,              tbl[i].e_inst);
`ifdef FETCH_PERF_CNT_EN
            if (i == 17) begin
                chk("perf_fetch_after_rst", perf_fetch_cnt, 32'd0);
                chk("perf_drop_after_rst",  perf_drop_cnt,  32'd0);
            end
            if (i == NV - 1) begin
                chk("perf_fetch_end", perf_fetch_cnt, 32'd1);
                chk("perf_drop_end",  perf_drop_cnt,  32'd3);
            end
`endif
        end

        // Streaming: memory answers one cycle after each handshake while Stall
        // toggles; every instruction must arrive in order with inst = ~pc.
        drive_idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        pending   = 1'b0;
        pend_addr = 32'd0;
        exp_pc    = 32'd0;
        got       = 0;
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
            Stall          = ((cyc % 4) == 1) || ((cyc % 4) == 2);
            imem_req_ready = 1'b1;
            imem_rsp_valid = pending;
            imem_rsp_data  = ~pend_addr;
            #1;
            hs       = imem_req_valid && imem_req_ready;
            hs_addr  = imem_addr;
            st       = Stall;
            rsp_sent = pending;
            @(posedge clk);
            #1;
            if (rsp_sent) pending = 1'b0;
            if (hs) begin
                pending   = 1'b1;
                pend_addr = hs_addr;
            end
            if (!st && IF_ID_valid) begin
                chk($sformatf("stream%0d_pc", got),   IF_ID_pc,   exp_pc);
                chk($sformatf("stream%0d_inst", got), IF_ID_inst, ~exp_pc);
                exp_pc = exp_pc + 32'd4;
                got++;
            end
        end
        chk("stream_count", got, 32'd8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
